// File: rtl/risc16b_mmio.sv
// Memory-mapped I/O page (0x7f00-0x7fff) on the risc16b data port:
// LED register, free-running cycle counter and an 8N1 UART transmitter.
module risc16b_mmio #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_addr,
    input  logic        d_oe,
    input  logic [1:0]  d_we,
    input  logic [15:0] d_dout,
    output logic        io_sel,
    output logic [15:0] io_din,
    output logic [15:0] led,
    output logic        uart_tx,
    output logic [1:0]  uart_state
);

    // Bus semantics: there is no ready/stall. A write is taken on the rising
    // edge where io_sel and any d_we lane are high; a read is combinational
    // whenever io_sel and d_oe are high, and the core samples it that cycle.

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    localparam logic [6:0] W_LED    = 7'd0;
    localparam logic [6:0] W_CYCLE  = 7'd1;
    localparam logic [6:0] W_UDATA  = 7'd2;
    localparam logic [6:0] W_USTAT  = 7'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    logic [6:0]  word;
    logic        unused_addr_lsb;
    logic        led_wr;
    logic        cycle_clr;
    logic        uart_load;
    logic        busy;
    logic [15:0] cycle;

    uart_state_t   state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_q, tx_n;

    assign io_sel          = (d_addr[15:8] == 8'h7f);
    assign word            = d_addr[7:1];
    assign unused_addr_lsb = d_addr[0];

    assign led_wr    = io_sel && (word == W_LED);
    assign cycle_clr = io_sel && (word == W_CYCLE) && (|d_we);
    assign busy      = (state != S_IDLE);
    // Writes landing while a frame is in flight are dropped, not queued.
    assign uart_load = io_sel && (word == W_UDATA) && d_we[1] && !busy;

    assign uart_tx    = tx_q;
    assign uart_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 16'h0000;
        end else if (led_wr) begin
            if (d_we[0]) led[15:8] <= d_dout[15:8];
            if (d_we[1]) led[7:0]  <= d_dout[7:0];
        end
    end

    // Clear has priority over the increment on the same edge.
    always_ff @(posedge clk) begin
        if (rst || cycle_clr) begin
            cycle <= 16'h0000;
        end else begin
            cycle <= cycle + 16'd1;
        end
    end

    always_comb begin
        io_din = 16'h0000;
        if (io_sel && d_oe) begin
            case (word)
                W_LED:   io_din = led;
                W_CYCLE: io_din = cycle;
                W_USTAT: io_din = {15'h0000, busy};
                default: io_din = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx_q    <= tx_n;
        end
    end

    // The next tx level is computed here and registered, so uart_tx is a
    // plain flop output; each bit boundary reloads the baud counter.
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx_q;
        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (uart_load) begin
                    shift_n = d_dout[7:0];
                    baud_n  = BAUD_MAX;
                    state_n = S_START;
                    tx_n    = 1'b0;
                end
            end
            S_START: begin
                if (baud == '0) begin
                    baud_n    = BAUD_MAX;
                    bit_idx_n = 3'd0;
                    state_n   = S_DATA;
                    tx_n      = shift[0];
                end else begin
                    baud_n = baud - BW'(1);
                end
            end
            S_DATA: begin
                if (baud == '0) begin
                    baud_n = BAUD_MAX;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shift_n   = {1'b0, shift[7:1]};
                        tx_n      = shift[1];
                    end
                end else begin
                    baud_n = baud - BW'(1);
                end
            end
            S_STOP: begin
                tx_n = 1'b1;
                if (baud == '0) begin
                    state_n = S_IDLE;
                end else begin
                    baud_n = baud - BW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_risc16b_mmio.sv
// Self-checking bench for risc16b_mmio: register map, CYCLE behaviour and
// UART framing with a short bit period.
module tb_risc16b_mmio;

    localparam int CPB = 4;

    logic        clk;
    logic        rst;
    logic [15:0] d_addr;
    logic        d_oe;
    logic [1:0]  d_we;
    logic [15:0] d_dout;
    logic        io_sel;
    logic [15:0] io_din;
    logic [15:0] led;
    logic        uart_tx;
    logic [1:0]  uart_state;

    logic [15:0] exp_q[$];
    int total;
    int bad;

    risc16b_mmio #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_addr     (d_addr),
        .d_oe       (d_oe),
        .d_we       (d_we),
        .d_dout     (d_dout),
        .io_sel     (io_sel),
        .io_din     (io_din),
        .led        (led),
        .uart_tx    (uart_tx),
        .uart_state (uart_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        d_addr = 16'h0000;
        d_oe   = 1'b0;
        d_we   = 2'b00;
        d_dout = 16'h0000;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] we);
        d_addr = addr;
        d_dout = data;
        d_we   = we;
        d_oe   = 1'b0;
        cycle();
        bus_idle();
    endtask

    task automatic read_expect(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        exp_q.push_back(exp);
        d_addr = addr;
        d_oe   = 1'b1;
        d_we   = 2'b00;
        #1;
        check(tag, io_din, exp_q.pop_front());
        d_oe = 1'b0;
    endtask

    // Sends one byte and follows the frame for 60 cycles; optionally injects
    // a second UART_DATA write at cycle collide_at.
    task automatic run_frame(input string tag, input logic [7:0] data, input int collide_at);
        int first_idle;
        logic saw_low_after;
        logic [9:0] bits;
        first_idle    = -1;
        saw_low_after = 1'b0;
        bits = {1'b1, data, 1'b0};
        for (int b = 0; b < 10; b++) exp_q.push_back({15'h0000, bits[b]});
        bus_write(16'h7f04, {8'h00, data}, 2'b10);
        for (int c = 0; c < 60; c++) begin
            if (c > 0) cycle();
            if (c == collide_at) begin
                d_addr = 16'h7f04;
                d_dout = 16'h00ff;
                d_we   = 2'b10;
                d_oe   = 1'b0;
            end else begin
                d_addr = 16'h7f06;
                d_we   = 2'b00;
                d_oe   = 1'b1;
            end
            #1;
            if (c < 40 && (c % CPB) == 2) begin
                check($sformatf("%s_bit%0d", tag, c / CPB), {15'h0000, uart_tx}, exp_q.pop_front());
            end
            if (c != collide_at && io_din[0] == 1'b0 && first_idle < 0) first_idle = c;
            if (c >= 40 && uart_tx == 1'b0) saw_low_after = 1'b1;
        end
        bus_idle();
        check({tag, "_busy_len"}, 16'(first_idle), 16'd40);
        check({tag, "_no_extra"}, {15'h0000, saw_low_after}, 16'h0000);
        check({tag, "_q_empty"}, 16'(exp_q.size()), 16'h0000);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_idle();

        // Reset
        cycle();
        rst = 1'b0;
        check("rst_led", led, 16'h0000);
        check("rst_tx", {15'h0000, uart_tx}, 16'h0001);
        check("rst_state", {14'h0000, uart_state}, 16'h0000);
        read_expect("rst_status", 16'h7f06, 16'h0000);
        read_expect("rst_cycle", 16'h7f02, 16'h0000);

        // CYCLE counting, clear and wrap
        repeat (100) cycle();
        read_expect("cycle_100", 16'h7f02, 16'h0064);
        d_oe = 1'b0;
        #1;
        check("oe_low_zero", io_din, 16'h0000);
        bus_write(16'h7f02, 16'h1234, 2'b01);
        read_expect("cycle_clr0", 16'h7f02, 16'h0000);
        cycle();
        read_expect("cycle_clr1", 16'h7f02, 16'h0001);
        repeat (65534) cycle();
        read_expect("cycle_ffff", 16'h7f02, 16'hffff);
        cycle();
        read_expect("cycle_wrap", 16'h7f02, 16'h0000);

        // LED byte lanes
        bus_write(16'h7f00, 16'ha55a, 2'b01);
        check("led_hi", led, 16'ha500);
        bus_write(16'h7f00, 16'h1234, 2'b10);
        check("led_lo", led, 16'ha534);
        d_addr = 16'h7e00;
        d_dout = 16'hffff;
        d_we   = 2'b11;
        #1;
        check("unmapped_sel", {15'h0000, io_sel}, 16'h0000);
        cycle();
        bus_idle();
        check("led_unmapped", led, 16'ha534);
        read_expect("led_read_odd", 16'h7f01, 16'ha534);
        bus_write(16'h7f0a, 16'hffff, 2'b11);
        check("led_other_off", led, 16'ha534);

        // d_we[0] alone on UART_DATA does not start a frame
        bus_write(16'h7f04, 16'h0055, 2'b01);
        check("udata_lane0_tx", {15'h0000, uart_tx}, 16'h0001);
        read_expect("udata_lane0_busy", 16'h7f06, 16'h0000);

        // UART frames
        run_frame("f55", 8'h55, -1);
        run_frame("fcol", 8'h55, 10);
        run_frame("fff", 8'hff, -1);

        // Reset mid-frame, data bit 3 (frame bit 4)
        bus_write(16'h7f04, 16'h0055, 2'b10);
        repeat (17) cycle();
        check("mid_bit3_tx", {15'h0000, uart_tx}, 16'h0000);
        read_expect("mid_busy", 16'h7f06, 16'h0001);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_tx", {15'h0000, uart_tx}, 16'h0001);
        check("abort_led", led, 16'h0000);
        read_expect("abort_busy", 16'h7f06, 16'h0000);
        read_expect("abort_cycle", 16'h7f02, 16'h0000);
        bus_write(16'h7f00, 16'hbeef, 2'b11);
        read_expect("unmapped_08", 16'h7f08, 16'h0000);
        read_expect("udata_read", 16'h7f04, 16'h0000);
        read_expect("led_read", 16'h7f00, 16'hbeef);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/risc16b_mmio.md
# risc16b_mmio

Memory-mapped I/O block on the risc16b data port, directly downstream of the core's `d_addr`/`d_dout`/`d_we`/`d_oe` outputs. It claims the 0x7f00–0x7fff page that main memory ignores. It holds the LED register, a free-running cycle counter and an 8N1 UART transmitter. Read data is muxed back to the core alongside memory read data.

## Interface
- `CLKS_PER_BIT`, default 434 — clock cycles per UART bit (50 MHz / 115200). Legal range is ≥ 2.
- `clk`  in  1  — system clock. All state changes on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `d_addr`  in  16  — core data address.
- `d_oe`  in  1  — core read strobe.
- `d_we`  in  2  — byte-lane write enables: bit0 → data[15:8], bit1 → data[7:0].
- `d_dout`  in  16  — core write data.
- `io_sel`  out  1  — high when `d_addr[15:8] == 8'h7f`. Combinational.
- `io_din`  out  16  — read data to the core. Combinational.
- `led`  out  16  — LED register.
- `uart_tx`  out  1  — serial output. Idles high.

## Operation
- Decode: word index is `d_addr[7:1]`. `d_addr[0]` is ignored. Accesses with `io_sel` = 0 have no effect.
- Register map, by byte offset:
  - 0x00 LED, RW: per-lane write.
  - 0x02 CYCLE, RO: 16-bit counter. A write with any lane set clears it.
  - 0x04 UART_DATA, WO: a write with `d_we[1]` set loads `d_dout[7:0]` and starts a frame. It is ignored if a frame is already in progress. `d_we[0]` alone does nothing. Reads return 0.
  - 0x06 UART_STATUS, RO: bit0 = busy; bits 15:1 read 0.
  - All other offsets: reads return 0, writes are ignored.
- `io_din` is the addressed register when `io_sel && d_oe`. Otherwise it is 16'h0000.
- CYCLE:
  - Increments every cycle that is not a reset or a clear.
  - Wraps 0xffff → 0x0000.
  - A clear on the same edge as an increment wins, so the counter reads 0x0000 the next cycle.
- UART FSM, states IDLE → START → DATA → STOP → IDLE:
  - IDLE: `uart_tx` = 1, busy = 0. An accepted write latches the byte into the shift register and moves to START.
  - START: `uart_tx` = 0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, each held for `CLKS_PER_BIT` cycles. A 3-bit index tracks the bit.
  - STOP: `uart_tx` = 1 for `CLKS_PER_BIT` cycles, then IDLE.
  - The baud counter is wide enough for `CLKS_PER_BIT - 1` and reloads at every bit boundary.
  - busy = 1 in START, DATA and STOP.
- A write to UART_DATA on the same edge that STOP completes is ignored, because busy is still 1 at that edge. Software must poll busy.

## Timing
- Reset values: `led` = 0x0000, CYCLE = 0x0000, `uart_tx` = 1, busy = 0, FSM in IDLE, shift register 0.
- Writes take effect on the rising edge where `io_sel` and `d_we` are asserted. The new value is visible on `io_din` and `led` the following cycle.
- Reads are zero-latency and combinational, matching main-memory read timing. The CYCLE value read is the current registered value.
- UART frame:
  - On edge N, the accepting write is sampled and the FSM enters START.
  - From edge N, `uart_tx` falls and busy reads 1.
  - At edge N + 10·`CLKS_PER_BIT`, `uart_tx` is high and the FSM is back in IDLE. busy = 0 is readable from that cycle.
- Reset during a frame aborts it. On the next edge `uart_tx` = 1 and busy = 0. `led` and CYCLE return to 0 on the same edge.
- `uart_tx` is driven directly from a flop. There is no combinational path from `d_*` to `uart_tx` or `led`.

## Test plan
- **Reset:** hold `rst` 1 cycle → `led` = 0x0000, `uart_tx` = 1. A read of 0x7f06 gives 0x0000, and a read of 0x7f02 gives 0x0000 on the first cycle after reset.
- **LED lanes:**
  - Write 0x7f00 with `d_dout` = 0xA55A, `d_we` = 2'b01 → `led` = 0xA500.
  - Then the same address with `d_dout` = 0x1234, `d_we` = 2'b10 → `led` = 0xA534.
  - A write of 0xFFFF to 0x7e00 → `led` unchanged, `io_sel` = 0.
- **CYCLE:**
  - After 100 cycles out of reset, a read of 0x7f02 gives 0x0064.
  - A write to 0x7f02 → reads 0x0000 the next cycle and 0x0001 the cycle after.
  - Force the counter to 0xffff → reads 0x0000 the next cycle.
- **UART frame, `CLKS_PER_BIT` = 4:**
  - Write 0x0055 to 0x7f04 → `uart_tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles.
  - busy = 1 for exactly 40 cycles, then 0.
- **UART busy collision:** during a frame of 0x55, write 0x00FF to 0x7f04 → the frame continues unchanged and no second frame follows. After busy clears, a write of 0x00FF sends 0,1×8,1.
- **Reset mid-frame and unmapped offsets:**
  - Assert `rst` in DATA bit 3 → `uart_tx` = 1 and busy = 0 on the next cycle.
  - A read of 0x7f08 or 0x7f04 gives 0x0000.
